// File: rtl/seq_multiplier_pkg.sv
// Shared CPU datapath definitions: default data width and multiplier FSM states.
package cpu_defs;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/seq_multiplier_twos_negate.sv
// Conditional two's-complement: y = neg ? -a : a, modulo 2^W.
module twos_negate #(
    parameter int unsigned W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: SIZE-bit operands, 2*SIZE-bit product after SIZE cycles.
module seq_multiplier
    import cpu_defs::*;
#(
    parameter int unsigned SIZE = DATA_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic [SIZE-1:0] src1_i,
    input  logic [SIZE-1:0] src2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [SIZE-1:0] result_lo_o,
    output logic [SIZE-1:0] result_hi_o
);

    localparam int unsigned CW = $clog2(SIZE);

    mul_state_e      state_q;
    logic [CW-1:0]   count_q;
    logic [SIZE-1:0] mcand_q;
    logic [SIZE-1:0] mplier_q;
    logic [SIZE-1:0] acc_q;
    logic            sign_flip_q;

    logic [SIZE-1:0]   mag1;
    logic [SIZE-1:0]   mag2;
    logic [SIZE:0]     sum;
    logic [SIZE-1:0]   acc_d;
    logic [SIZE-1:0]   mplier_d;
    logic [2*SIZE-1:0] prod_d;
    logic [2*SIZE-1:0] prod_fix;

    // Magnitudes are unsigned SIZE-bit, so |MIN| = 2^(SIZE-1) is representable.
    twos_negate #(.W(SIZE)) u_neg_src1 (
        .neg_i (signed_i & src1_i[SIZE-1]),
        .a_i   (src1_i),
        .y_o   (mag1)
    );

    twos_negate #(.W(SIZE)) u_neg_src2 (
        .neg_i (signed_i & src2_i[SIZE-1]),
        .a_i   (src2_i),
        .y_o   (mag2)
    );

    always_comb begin
        sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_d    = sum[SIZE:1];
        mplier_d = {sum[0], mplier_q[SIZE-1:1]};
        prod_d   = {acc_d, mplier_d};
    end

    twos_negate #(.W(2*SIZE)) u_neg_prod (
        .neg_i (sign_flip_q),
        .a_i   (prod_d),
        .y_o   (prod_fix)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= MUL_IDLE;
            count_q     <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            sign_flip_q <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            result_lo_o <= '0;
            result_hi_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                MUL_IDLE, MUL_DONE: begin
                    if (start_i) begin
                        mcand_q     <= mag1;
                        mplier_q    <= mag2;
                        acc_q       <= '0;
                        sign_flip_q <= signed_i & (src1_i[SIZE-1] ^ src2_i[SIZE-1]);
                        count_q     <= '0;
                        state_q     <= MUL_RUN;
                        busy_o      <= 1'b1;
                    end else begin
                        state_q <= MUL_IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                MUL_RUN: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_d;
                    count_q  <= count_q + CW'(1);
                    // Last bit: take the product straight from this step's shift result.
                    if (count_q == CW'(SIZE - 1)) begin
                        result_lo_o <= prod_fix[SIZE-1:0];
                        result_hi_o <= prod_fix[2*SIZE-1:SIZE];
                        state_q     <= MUL_DONE;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= MUL_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
